// File: rtl/y_tri_pkg.sv
// Shared types and index helpers for the Y-gate triangle evaluator.
// Triangle bit (r,c) lives at r*(r+1)/2+c, apex first.
package y_tri_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int tri_size(input int n);
    return (n + 1) * (n + 2) / 2;
  endfunction

  function automatic int tri_idx(input int r, input int c);
    return r * (r + 1) / 2 + c;
  endfunction

endpackage

// File: rtl/y_maj_layer.sv
// One majority reduction layer over a packed triangle.
// Rows at or beyond k, and the bottom row, are zero filled.
module y_maj_layer
  import y_tri_pkg::*;
#(
  parameter  int N  = 4,
  localparam int W  = tri_size(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic [W-1:0]  d,
  input  logic [CW-1:0] k,
  output logic [W-1:0]  q
);

  for (genvar r = 0; r <= N; r++) begin : g_r
    for (genvar c = 0; c <= r; c++) begin : g_c
      if (r == N) begin : g_z
        assign q[tri_idx(r, c)] = 1'b0;
      end else begin : g_m
        logic a;
        logic b;
        logic e;
        logic act;
        assign a   = d[tri_idx(r, c)];
        assign b   = d[tri_idx(r + 1, c)];
        assign e   = d[tri_idx(r + 1, c + 1)];
        assign act = k > CW'(r);
        assign q[tri_idx(r, c)] =
          act & ((a & b) | (a & e) | (b & e));
      end
    end
  end

endmodule

// File: rtl/y_tri_eval.sv
// Sequential Y_N evaluator: one majority layer per clock,
// result returned over a valid/ready handshake.
module y_tri_eval
  import y_tri_pkg::*;
#(
  parameter  int N  = 4,
  localparam int W  = tri_size(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] tri_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         y_out,
  output logic         busy
);

  state_t        state;
  logic [W-1:0]  tri_q;
  logic [CW-1:0] cnt;
  logic [W-1:0]  nxt;

  y_maj_layer #(.N(N)) u_layer (
    .d (tri_q),
    .k (cnt),
    .q (nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tri_q     <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y_out     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            tri_q    <= tri_in;
            cnt      <= CW'(N);
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          tri_q <= nxt;
          cnt   <= cnt - 1'b1;
          // cnt==1 means this layer leaves only the apex
          if (cnt == CW'(1)) begin
            y_out     <= nxt[0];
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y_tri_eval.sv
// Scoreboard bench for y_tri_eval at N=4 and N=2.
// Expected bits are queued at accept and popped by monitors.
module tb_y_tri_eval;

  logic clk = 1'b0;
  logic rst_n;

  logic        in_valid4, in_ready4, out_valid4;
  logic        out_ready4, y_out4, busy4;
  logic [14:0] tri_in4;

  logic        in_valid2, in_ready2, out_valid2;
  logic        out_ready2, y_out2, busy2;
  logic [5:0]  tri_in2;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic q4[$];
  logic q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  y_tri_eval #(.N(4)) u4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .tri_in    (tri_in4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .y_out     (y_out4),
    .busy      (busy4)
  );

  y_tri_eval #(.N(2)) u2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .tri_in    (tri_in2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .y_out     (y_out2),
    .busy      (busy2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic y_model(input logic [14:0] t, input int n);
    logic a[5][5];
    for (int r = 0; r <= n; r++)
      for (int c = 0; c <= r; c++)
        a[r][c] = t[r * (r + 1) / 2 + c];
    for (int k = n; k >= 1; k--)
      for (int r = 0; r < k; r++)
        for (int c = 0; c <= r; c++)
          a[r][c] = (a[r][c] & a[r+1][c]) | (a[r][c] & a[r+1][c+1])
                  | (a[r+1][c] & a[r+1][c+1]);
    return a[0][0];
  endfunction

  // monitors: pop on handshake, hold-check while stalled
  always @(negedge clk) begin
    if (rst_n && out_valid4) begin
      if (q4.size() == 0) begin
        if (out_ready4) chk("unexpected_out4", 32'd1, 32'd0);
      end else if (out_ready4) begin
        chk("y4", y_out4, q4.pop_front());
      end else begin
        chk("y4_hold", y_out4, q4[0]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid2) begin
      if (q2.size() == 0) begin
        if (out_ready2) chk("unexpected_out2", 32'd1, 32'd0);
      end else if (out_ready2) begin
        chk("y2", y_out2, q2.pop_front());
      end else begin
        chk("y2_hold", y_out2, q2[0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [14:0] t, input logic e,
                       input bit push);
    int n = 0;
    while (!in_ready4 && n < 100) begin
      step();
      n++;
    end
    if (!in_ready4) chk("send4_timeout", 32'd0, 32'd1);
    in_valid4 = 1'b1;
    tri_in4   = t;
    if (push) q4.push_back(e);
    step();
    in_valid4 = 1'b0;
  endtask

  task automatic send2(input logic [5:0] t, input logic e);
    int n = 0;
    while (!in_ready2 && n < 100) begin
      step();
      n++;
    end
    if (!in_ready2) chk("send2_timeout", 32'd0, 32'd1);
    in_valid2 = 1'b1;
    tri_in2   = t;
    q2.push_back(e);
    step();
    in_valid2 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q4.size() != 0 || q2.size() != 0 || !in_ready4
            || !in_ready2) && n < 200) begin
      step();
      n++;
    end
    chk("drain_timeout", n < 200, 32'd1);
  endtask

  logic [5:0]  v2[4] = '{6'b001011, 6'b000011, 6'b001010, 6'b111111};
  logic        e2[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [14:0] v4[6] = '{15'h7FFF, 15'h0000, 15'h7FCB,
                         15'h7C00, 15'h03FF, 15'h0001};
  logic        e4[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst_n = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; tri_in4 = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; tri_in2 = '0;
    repeat (3) step();
    chk("rst_in_ready4", in_ready4, 32'd1);
    chk("rst_out_valid4", out_valid4, 32'd0);
    chk("rst_busy4", busy4, 32'd0);
    chk("rst_y4", y_out4, 32'd0);
    chk("rst_in_ready2", in_ready2, 32'd1);
    chk("rst_out_valid2", out_valid2, 32'd0);
    rst_n = 1'b1;
    step();

    // N=2 latency: valid appears exactly N edges after accept
    send2(v2[0], e2[0]);
    chk("lat2_busy", busy2, 32'd1);
    chk("lat2_t0", out_valid2, 32'd0);
    step();
    chk("lat2_t1", out_valid2, 32'd0);
    step();
    chk("lat2_t2", out_valid2, 32'd1);
    drain();
    for (int i = 1; i < 4; i++) send2(v2[i], e2[i]);
    drain();

    // N=4 directed
    for (int i = 0; i < 6; i++) send4(v4[i], e4[i], 1'b1);
    drain();

    // backpressure with a rejected in_valid pulse
    out_ready4 = 1'b0;
    send4(15'h7FFF, 1'b1, 1'b1);
    begin
      int n = 0;
      while (!out_valid4 && n < 20) begin
        step();
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid4, 32'd1);
      chk("bp_in_ready", in_ready4, 32'd0);
      chk("bp_busy", busy4, 32'd1);
      if (i == 2) begin
        in_valid4 = 1'b1;
        tri_in4   = 15'h0000;
      end
      step();
      in_valid4 = 1'b0;
    end
    out_ready4 = 1'b1;
    repeat (12) step();
    chk("bp_idle", in_ready4, 32'd1);
    drain();

    // reset in the second RUN step aborts with no output
    send4(15'h7FFF, 1'b1, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready4, 32'd1);
    chk("abort_out_valid", out_valid4, 32'd0);
    chk("abort_busy", busy4, 32'd0);
    step();
    chk("abort_hold_valid", out_valid4, 32'd0);
    rst_n = 1'b1;
    repeat (12) step();
    chk("abort_no_out", out_valid4, 32'd0);

    // back-to-back with in_valid held high
    begin
      int last = 0;
      in_valid4 = 1'b1;
      for (int i = 0; i < 6; i++) begin
        int n = 0;
        while (!in_ready4 && n < 50) begin
          step();
          n++;
        end
        tri_in4 = v4[i];
        q4.push_back(e4[i]);
        if (i > 0) chk("b2b_spacing", cyc - last, 32'd6);
        last = cyc;
        step();
      end
      in_valid4 = 1'b0;
    end
    drain();

    // random against the software model
    for (int i = 0; i < 1000; i++) begin
      logic [14:0] t;
      t = 15'($urandom);
      send4(t, y_model(t, 4), 1'b1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
